dp_share_arbiter: RTL and testbench
===================================

// Module: dp_share_arbiter
// PURPOSE
//  Shares one registered select/operand datapath (inputs a, b, s, output x) between two
//  requesters. Arbitrates, drives operands with a one-cycle load enable (also the datapath
//  clock-gate enable), waits a fixed latency, then returns the result with a valid/ready
//  handshake. Sits between the request sources and the gated datapath instance.
// PARAMETERS
//  WIDTH    17  operand and result width, in bits
//  LATENCY  1   cycles from the dp_en cycle to dp_x being valid; legal range 1..15
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  rst        in   1      asynchronous, active-high reset
//  r0_valid   in   1      requester 0 has an operation
//  r0_ready   out  1      requester 0 operation accepted this cycle
//  r0_a       in   WIDTH  requester 0 operand a
//  r0_b       in   WIDTH  requester 0 operand b
//  r0_s       in   1      requester 0 select
//  r1_valid   in   1      requester 1 has an operation
//  r1_ready   out  1      requester 1 operation accepted this cycle
//  r1_a       in   WIDTH  requester 1 operand a
//  r1_b       in   WIDTH  requester 1 operand b
//  r1_s       in   1      requester 1 select
//  dp_a       out  WIDTH  datapath operand a (registered)
//  dp_b       out  WIDTH  datapath operand b (registered)
//  dp_s       out  1      datapath select (registered)
//  dp_en      out  1      datapath load / clock-gate enable; pulses for 1 cycle per operation
//  dp_x       in   WIDTH  datapath result
//  rsp_valid  out  1      result available
//  rsp_ready  in   1      consumer accepts the result
//  rsp_id     out  1      requester that owns the result
//  rsp_data   out  WIDTH  captured result
// BEHAVIOUR
//  - Reset: all outputs are 0; FSM=IDLE; cnt=0; rr_ptr=0 (requester 0 has priority first).
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE: if any rN_valid, pick a winner. rN_ready=1 for the winner only, in this cycle.
//    On this edge: latch winner operands into dp_a/dp_b/dp_s, latch rsp_id, go to ISSUE.
//  - Arbitration is round-robin. When both are valid, requester rr_ptr wins.
//    rr_ptr <= ~winner on every grant. When one is valid, it wins regardless of rr_ptr.
//  - ISSUE: dp_en=1 for exactly this one cycle; cnt <= LATENCY-1; go to WAIT.
//  - WAIT: when cnt==0, capture rsp_data <= dp_x and go to RESP. Otherwise cnt decrements.
//    With LATENCY=1, capture happens in the first WAIT cycle.
//  - Latency: grant edge to rsp_valid high is LATENCY+2 cycles.
//  - RESP: rsp_valid=1; rsp_data and rsp_id are stable until rsp_valid && rsp_ready.
//    On that handshake go to IDLE. No new grant in the handshake cycle.
//  - dp_a, dp_b, dp_s hold their last value outside ISSUE. dp_en=0 in every state except ISSUE.
//  - Only one operation is in flight. rN_ready=0 in ISSUE, WAIT and RESP.
//  - A requester that drops valid before it is granted is simply skipped; no error.
//  - rsp_ready is ignored outside RESP.
//  - rst asserted mid-operation: immediate return to reset values. The in-flight result is
//    discarded; dp_en falls at once.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN
//  - defined: fixed priority. r0 always wins a simultaneous request; rr_ptr is not
//    implemented.
//  - undefined (default): round-robin as described above.
// TESTING
//  1. Reset: rst=1 then 0 -> all outputs 0, FSM idle, dp_en never pulses.
//  2. Single op, LATENCY=1: r0 a=2, b=1, s=1 -> dp_a=2, dp_b=1, dp_s=1, one dp_en pulse.
//     rsp_valid 3 cycles after grant, rsp_id=0, rsp_data=dp_x.
//  3. Contention, default build: r0 and r1 held valid for 4 ops -> grants r0,r1,r0,r1.
//     With ARB_FIXED_PRIO_EN: grant order is r0,r0,r0,r0.
//  4. Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data (a=3, b=1, s=0)
//     stay stable; no grant, no dp_en; completes on the first rsp_ready=1 cycle.
//  5. LATENCY=4: single op -> dp_x sampled exactly 4 cycles after dp_en.
//     rsp_valid 6 cycles after grant.
//  6. Reset mid-WAIT: rst=1 -> rsp_valid stays 0 and dp_en=0 immediately.
//     After release, a new r1 request (a=3, b=1, s=1) completes normally.

Source files
------------

// File: rtl/dp_share_arbiter.sv
// Purpose : shares one registered select/operand datapath between two requesters.
// Latency : grant edge to rsp_valid is LATENCY+2 cycles; one operation in flight at a time.
// Backpressure: the result is held in RESP until rsp_ready; no new grant until then.
//
// Ports:
//   clk, rst               single clock, asynchronous active-high reset
//   r0_* / r1_*            requester valid/ready plus operands a, b and select s
//   dp_a, dp_b, dp_s       registered operands presented to the shared datapath
//   dp_en                  one-cycle load / clock-gate enable per operation
//   dp_x                   datapath result, valid LATENCY cycles after the dp_en cycle
//   rsp_valid/ready/id/data  result handshake with the owning requester id
//
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (r0 always wins a tie);
// the default build arbitrates round-robin.

module dp_share_arbiter #(
    parameter int WIDTH   = 17,
    parameter int LATENCY = 1     // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r0_s,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic             r1_s,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_s,
    output logic             dp_en,
    input  logic [WIDTH-1:0] dp_x,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        req_any;
    logic        winner;

    assign req_any = r0_valid | r1_valid;

`ifdef ARB_FIXED_PRIO_EN
    // r0 wins whenever it asks; r1 only when r0 is absent.
    assign winner = ~r0_valid;
`else
    logic rr_ptr;   // requester that wins the next tie

    always_comb begin
        winner = r1_valid;              // single requester wins regardless of pointer
        if (r0_valid && r1_valid)
            winner = rr_ptr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= 1'b0;
        else if (state == IDLE && req_any)
            rr_ptr <= ~winner;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any)   state_nxt = ISSUE;
            ISSUE:                  state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Outputs. Ready is gated with rst so every output reads 0 while reset is held.
    always_comb begin
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        dp_en     = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                r0_ready = ~rst & req_any & ~winner;
                r1_ready = ~rst & req_any &  winner;
            end
            ISSUE:   dp_en     = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand, id, latency counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_a     <= '0;
            dp_b     <= '0;
            dp_s     <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        dp_a   <= winner ? r1_a : r0_a;
                        dp_b   <= winner ? r1_b : r0_b;
                        dp_s   <= winner ? r1_s : r0_s;
                        rsp_id <= winner;
                    end
                end
                ISSUE: cnt <= 4'(LATENCY - 1);
                WAIT: begin
                    // cnt reaches 0 in the cycle dp_x becomes valid
                    if (cnt == '0)
                        rsp_data <= dp_x;
                    else
                        cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Bench for dp_share_arbiter: a LATENCY=1 instance driven cycle by cycle against a
// transaction-level model, and a LATENCY=4 instance exercised with directed operations.
// Each instance sees a behavioural datapath whose result is correct only in the exact cycle.

module tb_dp_share_arbiter;

    localparam int W = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // LATENCY=1 instance
    logic         l1_r0_valid, l1_r0_ready, l1_r0_s, l1_r1_valid, l1_r1_ready, l1_r1_s;
    logic [W-1:0] l1_r0_a, l1_r0_b, l1_r1_a, l1_r1_b;
    logic [W-1:0] l1_dp_a, l1_dp_b, l1_dp_x, l1_rsp_data;
    logic         l1_dp_s, l1_dp_en, l1_rsp_valid, l1_rsp_ready, l1_rsp_id;

    // LATENCY=4 instance
    logic         l4_r0_valid, l4_r0_ready, l4_r0_s, l4_r1_valid, l4_r1_ready, l4_r1_s;
    logic [W-1:0] l4_r0_a, l4_r0_b, l4_r1_a, l4_r1_b;
    logic [W-1:0] l4_dp_a, l4_dp_b, l4_dp_x, l4_rsp_data;
    logic         l4_dp_s, l4_dp_en, l4_rsp_valid, l4_rsp_ready, l4_rsp_id;

    dp_share_arbiter #(.WIDTH(W), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .r0_valid(l1_r0_valid), .r0_ready(l1_r0_ready), .r0_a(l1_r0_a), .r0_b(l1_r0_b), .r0_s(l1_r0_s),
        .r1_valid(l1_r1_valid), .r1_ready(l1_r1_ready), .r1_a(l1_r1_a), .r1_b(l1_r1_b), .r1_s(l1_r1_s),
        .dp_a(l1_dp_a), .dp_b(l1_dp_b), .dp_s(l1_dp_s), .dp_en(l1_dp_en), .dp_x(l1_dp_x),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_id(l1_rsp_id), .rsp_data(l1_rsp_data)
    );

    dp_share_arbiter #(.WIDTH(W), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst),
        .r0_valid(l4_r0_valid), .r0_ready(l4_r0_ready), .r0_a(l4_r0_a), .r0_b(l4_r0_b), .r0_s(l4_r0_s),
        .r1_valid(l4_r1_valid), .r1_ready(l4_r1_ready), .r1_a(l4_r1_a), .r1_b(l4_r1_b), .r1_s(l4_r1_s),
        .dp_a(l4_dp_a), .dp_b(l4_dp_b), .dp_s(l4_dp_s), .dp_en(l4_dp_en), .dp_x(l4_dp_x),
        .rsp_valid(l4_rsp_valid), .rsp_ready(l4_rsp_ready), .rsp_id(l4_rsp_id), .rsp_data(l4_rsp_data)
    );

    // Behavioural datapath function
    function automatic logic [W-1:0] dp_fn(logic [W-1:0] a, logic [W-1:0] b, logic s);
        return s ? W'(a + b) : W'(a - b);
    endfunction

    // Datapaths: operands are taken on the dp_en edge and the result is shown only
    // LATENCY cycles later; any other cycle shows the inverted value.
    logic         l1_pv;
    logic [W-1:0] l1_pd;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            l1_pv <= 1'b0;
            l1_pd <= '0;
        end else begin
            l1_pv <= l1_dp_en;
            l1_pd <= dp_fn(l1_dp_a, l1_dp_b, l1_dp_s);
        end
    end
    assign l1_dp_x = l1_pv ? l1_pd : ~l1_pd;

    logic [3:0]   l4_pv;
    logic [W-1:0] l4_pd [4];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            l4_pv <= '0;
            for (int i = 0; i < 4; i++) l4_pd[i] <= '0;
        end else begin
            l4_pv    <= {l4_pv[2:0], l4_dp_en};
            l4_pd[0] <= dp_fn(l4_dp_a, l4_dp_b, l4_dp_s);
            for (int i = 1; i < 4; i++) l4_pd[i] <= l4_pd[i-1];
        end
    end
    assign l4_dp_x = l4_pv[3] ? l4_pd[3] : ~l4_pd[3];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level model of the LATENCY=1 instance
    localparam int L1 = 1;
    bit           m_busy;
    int           m_age;      // cycles since the grant cycle
    bit           m_last;     // last winner; reset value makes r0 first in a tie
    bit           m_id;
    logic [W-1:0] m_a, m_b;
    logic         m_s;
    bit           grants[$];

    function automatic bit tie_winner();
`ifdef ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return ~m_last;
`endif
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_age  = 0;
        m_last = 1'b1;
    endtask

    // One cycle of the LATENCY=1 instance: check at negedge, return just after the next posedge.
    task automatic tick();
        bit any, win;
        @(negedge clk);
        any = l1_r0_valid | l1_r1_valid;
        if (!m_busy) begin
            win = (l1_r0_valid && l1_r1_valid) ? tie_winner() : l1_r1_valid;
            chk("r0_ready", l1_r0_ready, any && !win);
            chk("r1_ready", l1_r1_ready, any && win);
            chk("dp_en_idle", l1_dp_en, 0);
            chk("rsp_valid_idle", l1_rsp_valid, 0);
            if (any) begin
                m_busy = 1;
                m_age  = 1;
                m_id   = win;
                m_last = win;
                m_a    = win ? l1_r1_a : l1_r0_a;
                m_b    = win ? l1_r1_b : l1_r0_b;
                m_s    = win ? l1_r1_s : l1_r0_s;
                grants.push_back(win);
            end
        end else begin
            chk("r0_ready_busy", l1_r0_ready, 0);
            chk("r1_ready_busy", l1_r1_ready, 0);
            chk("dp_en", l1_dp_en, m_age == 1);
            chk("dp_a", l1_dp_a, m_a);
            chk("dp_b", l1_dp_b, m_b);
            chk("dp_s", l1_dp_s, m_s);
            chk("rsp_valid", l1_rsp_valid, m_age >= L1 + 2);
            if (m_age >= L1 + 2) begin
                chk("rsp_id", l1_rsp_id, m_id);
                chk("rsp_data", l1_rsp_data, dp_fn(m_a, m_b, m_s));
                if (l1_rsp_ready) m_busy = 0;
            end
            if (m_busy) m_age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk("rst_l1_dp_en", l1_dp_en, 0);
            chk("rst_l1_rsp_valid", l1_rsp_valid, 0);
            chk("rst_l4_rsp_valid", l4_rsp_valid, 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic l1_idle();
        l1_r0_valid = 0; l1_r1_valid = 0;
    endtask

    // Single directed operation on the LATENCY=4 instance. abort_at>0 returns early
    // at that many cycles after the grant cycle, leaving the operation in flight.
    task automatic l4_op(bit id, logic [W-1:0] a, logic [W-1:0] b, logic s, int abort_at);
        bit got;
        int t;
        int en_cnt;
        l4_r0_valid = !id; l4_r0_a = a; l4_r0_b = b; l4_r0_s = s;
        l4_r1_valid = id;  l4_r1_a = a; l4_r1_b = b; l4_r1_s = s;
        l4_rsp_ready = 1'b1;
        @(negedge clk);
        got = id ? l4_r1_ready : l4_r0_ready;
        chk("l4_grant", got, 1);
        @(posedge clk);
        #1;
        l4_r0_valid = 0;
        l4_r1_valid = 0;
        t = 0;
        en_cnt = 0;
        got = 0;
        while (!got && t < 40) begin
            @(negedge clk);
            t++;
            if (l4_dp_en) en_cnt++;
            got = l4_rsp_valid;
            if (abort_at > 0 && t == abort_at) return;
            if (!got) begin
                @(posedge clk);
                #1;
            end
        end
        chk("l4_latency", t, 6);
        chk("l4_dp_en_pulses", en_cnt, 1);
        chk("l4_rsp_id", l4_rsp_id, id);
        chk("l4_rsp_data", l4_rsp_data, dp_fn(a, b, s));
        @(posedge clk);
        #1;
        chk("l4_rsp_valid_after", l4_rsp_valid, 0);
    endtask

    initial begin
        int n;
        l1_r0_valid = 1; l1_r1_valid = 1;           // ready must still read 0 in reset
        l1_r0_a = '0; l1_r0_b = '0; l1_r0_s = 0;
        l1_r1_a = '0; l1_r1_b = '0; l1_r1_s = 0;
        l1_rsp_ready = 1;
        l4_r0_valid = 0; l4_r1_valid = 0;
        l4_r0_a = '0; l4_r0_b = '0; l4_r0_s = 0;
        l4_r1_a = '0; l4_r1_b = '0; l4_r1_s = 0;
        l4_rsp_ready = 1;
        model_reset();

        // Reset state
        #2;
        chk("rst_r0_ready", l1_r0_ready, 0);
        chk("rst_r1_ready", l1_r1_ready, 0);
        chk("rst_dp_a", l1_dp_a, 0);
        chk("rst_dp_b", l1_dp_b, 0);
        chk("rst_dp_s", l1_dp_s, 0);
        chk("rst_rsp_id", l1_rsp_id, 0);
        chk("rst_rsp_data", l1_rsp_data, 0);
        l1_idle();
        do_reset();
        repeat (3) tick();                          // idle: no dp_en, no ready

        // Single op, LATENCY=1
        l1_r0_valid = 1; l1_r0_a = 17'd2; l1_r0_b = 17'd1; l1_r0_s = 1;
        tick();
        l1_idle();
        repeat (4) tick();
        chk("single_grant_id", grants.size() == 1 ? grants[0] : 1'bx, 0);

        // Contention from a fresh pointer
        l1_idle();
        do_reset();
        grants.delete();
        l1_r0_valid = 1; l1_r1_valid = 1;
        n = 0;
        while (grants.size() < 4 && n < 60) begin
            l1_r0_a = W'($urandom); l1_r0_b = W'($urandom); l1_r0_s = 1'($urandom);
            l1_r1_a = W'($urandom); l1_r1_b = W'($urandom); l1_r1_s = 1'($urandom);
            tick();
            n++;
        end
        l1_idle();
        chk("contention_grants", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef ARB_FIXED_PRIO_EN
            chk("contention_order", grants[i], 0);
`else
            chk("contention_order", grants[i], i % 2);
`endif
        end
        repeat (4) tick();

        // Backpressure: result held, no grant while rsp_ready is low
        l1_rsp_ready = 0;
        l1_r0_valid = 1; l1_r0_a = 17'd3; l1_r0_b = 17'd1; l1_r0_s = 0;
        tick();
        l1_r0_valid = 0;
        repeat (3) tick();                          // reach RESP
        chk("bp_rsp_valid", l1_rsp_valid, 1);
        chk("bp_rsp_data", l1_rsp_data, 17'd2);
        l1_r0_valid = 1; l1_r1_valid = 1;
        repeat (5) tick();
        l1_rsp_ready = 1;
        l1_idle();
        tick();                                     // handshake
        chk("bp_done", l1_rsp_valid, 0);
        repeat (2) tick();

        // Randomized traffic
        grants.delete();
        for (int i = 0; i < 1500; i++) begin
            l1_r0_valid = ($urandom_range(0, 1) == 1);
            l1_r1_valid = ($urandom_range(0, 2) != 0);
            l1_r0_a = W'($urandom); l1_r0_b = W'($urandom); l1_r0_s = 1'($urandom);
            l1_r1_a = W'($urandom); l1_r1_b = W'($urandom); l1_r1_s = 1'($urandom);
            l1_rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        l1_idle();
        l1_rsp_ready = 1;
        repeat (6) tick();
        chk("random_grants_seen", grants.size() > 50, 1);

        // LATENCY=4 single op
        l4_op(1'b0, 17'd5, 17'd7, 1'b1, 0);
        l4_op(1'b1, 17'd9, 17'd4, 1'b0, 0);

        // Reset in the middle of WAIT
        l4_op(1'b0, 17'd6, 17'd2, 1'b1, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_dp_en", l4_dp_en, 0);
        chk("midrst_rsp_valid", l4_rsp_valid, 0);
        chk("midrst_dp_a", l4_dp_a, 0);
        repeat (8) begin
            @(negedge clk);
            chk("midrst_hold_rsp_valid", l4_rsp_valid, 0);
            chk("midrst_hold_dp_en", l4_dp_en, 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        l4_op(1'b1, 17'd3, 17'd1, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
